// File: rtl/pipeline_defs.sv
// ---------------------------------------------------------------------------
// pipeline_defs
//   Definitions shared by the 5-stage MIPS pipeline stages:
//   - control field widths (ALUOp, RegDst, MemtoReg, funct)
//   - select encodings for RegDst and MemtoReg
//   - REG_ZERO, the hard-wired zero register specifier
//   - ctrl_t, the decoded control bundle carried from ID into EX
// ---------------------------------------------------------------------------
package pipeline_defs;

  localparam int ALUOP_W    = 4;
  localparam int REGDST_W   = 2;
  localparam int MEMTOREG_W = 2;
  localparam int FUNCT_W    = 6;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // RegDst select: which field names the destination register
  typedef enum logic [REGDST_W-1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } regdst_e;

  // MemtoReg select: which value is written back
  typedef enum logic [MEMTOREG_W-1:0] {
    MEMTOREG_ALU = 2'd0,
    MEMTOREG_MEM = 2'd1,
    MEMTOREG_PC4 = 2'd2
  } memtoreg_e;

  // Decoded control bundle. Select fields are kept as plain vectors so
  // the bundle can be zeroed with '0 without enum casts.
  typedef struct packed {
    logic                  branch;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src1;
    logic                  alu_src2;
    logic [REGDST_W-1:0]   reg_dst;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic [ALUOP_W-1:0]    alu_op;
    logic [FUNCT_W-1:0]    funct;
  } ctrl_t;

  // A bubble carries no side effects: everything zero (sll $0,$0,0).
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard detector. Raises hz when the
//   instruction in EX is a load whose destination (rt) is read by the
//   instruction in ID. Register $0 never raises a hazard.
//
// Ports
//   ex_MemRead  in   EX instruction is a load
//   ex_rt       in   EX load destination register
//   id_rs       in   ID source register rs (always read)
//   id_rt       in   ID register rt
//   id_uses_rt  in   ID instruction reads rt as a source
//   hz          out  load-use hazard
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hz
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  // rt only counts as a dependency when ID actually reads it (not for
  // lui/addi/lw, where rt is a destination).
  assign rt_match = id_uses_rt & (ex_rt == id_rt);

  assign hz = ex_MemRead & (ex_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage MIPS pipeline. Registers the
//   decoded control bundle, operands and register specifiers from ID and
//   presents them to EX one cycle later. Detects load-use hazards, drives
//   the stall to PC/IF-ID, and loads a bubble on a stall or on a taken-
//   branch flush from EX.
//
// Optional feature: define ID_EX_PERF_EN to add the bubble_cnt/flush_cnt
// performance counter ports and their logic.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   id_*                decoded control, operands and specifiers from ID
//   id_uses_rt          ID instruction reads rt as a source
//   flush_ex            branch taken in EX; squash the ID instruction
//   ex_*                registered copies presented to EX
//   stall               hold PC and IF/ID this cycle (combinational)
//   bubble_cnt          hazard-only bubbles loaded   (ID_EX_PERF_EN)
//   flush_cnt           edges with flush_ex asserted (ID_EX_PERF_EN)
// ---------------------------------------------------------------------------
module id_ex_stage
  import pipeline_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  id_Branch,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_ALUSrc1,
  input  logic                  id_ALUSrc2,
  input  logic [REGDST_W-1:0]   id_RegDst,
  input  logic [MEMTOREG_W-1:0] id_MemtoReg,
  input  logic [ALUOP_W-1:0]    id_ALUOp,
  input  logic [FUNCT_W-1:0]    id_Funct,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_W-1:0]      id_shamt,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_uses_rt,
  input  logic                  flush_ex,

  output logic                  ex_Branch,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_ALUSrc1,
  output logic                  ex_ALUSrc2,
  output logic [REGDST_W-1:0]   ex_RegDst,
  output logic [MEMTOREG_W-1:0] ex_MemtoReg,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic [FUNCT_W-1:0]    ex_Funct,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_W-1:0]      ex_shamt,
  output logic [REG_W-1:0]      ex_rs,
  output logic [REG_W-1:0]      ex_rt,
  output logic [REG_W-1:0]      ex_rd,
  output logic                  stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]           bubble_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  // -------------------------------------------------------------------------
  // Pipeline register state
  // -------------------------------------------------------------------------
  ctrl_t             ctrl_q,     ctrl_d;
  logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [REG_W-1:0]  shamt_q,    shamt_d;
  logic [REG_W-1:0]  rs_q,       rs_d;
  logic [REG_W-1:0]  rt_q,       rt_d;
  logic [REG_W-1:0]  rd_q,       rd_d;

  ctrl_t id_ctrl;
  logic  hz;
  logic  bubble;

  assign id_ctrl = '{
    branch:     id_Branch,
    reg_write:  id_RegWrite,
    mem_read:   id_MemRead,
    mem_write:  id_MemWrite,
    alu_src1:   id_ALUSrc1,
    alu_src2:   id_ALUSrc2,
    reg_dst:    id_RegDst,
    mem_to_reg: id_MemtoReg,
    alu_op:     id_ALUOp,
    funct:      id_Funct
  };

  // -------------------------------------------------------------------------
  // Hazard detection: looks at the load currently in EX (registered) and the
  // sources of the instruction currently in ID.
  // -------------------------------------------------------------------------
  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .ex_MemRead (ctrl_q.mem_read),
    .ex_rt      (rt_q),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hz         (hz)
  );

  // A flush redirects the PC, so it must not be held by a concurrent stall;
  // the squashed instruction is discarded anyway.
  assign stall  = hz & ~flush_ex;
  assign bubble = flush_ex | hz;

  // -------------------------------------------------------------------------
  // Next-state: a bubble is bit-identical to the reset state so EX sees a
  // plain sll $0,$0,0.
  // -------------------------------------------------------------------------
  always_comb begin
    ctrl_d     = id_ctrl;
    pc_plus4_d = id_pc_plus4;
    rs_data_d  = id_rs_data;
    rt_data_d  = id_rt_data;
    imm_d      = id_imm;
    shamt_d    = id_shamt;
    rs_d       = id_rs;
    rt_d       = id_rt;
    rd_d       = id_rd;
    if (bubble) begin
      ctrl_d     = CTRL_BUBBLE;
      pc_plus4_d = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      shamt_d    = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= CTRL_BUBBLE;
      pc_plus4_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      shamt_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_plus4_q <= pc_plus4_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      shamt_q    <= shamt_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs to EX
  // -------------------------------------------------------------------------
  assign ex_Branch   = ctrl_q.branch;
  assign ex_RegWrite = ctrl_q.reg_write;
  assign ex_MemRead  = ctrl_q.mem_read;
  assign ex_MemWrite = ctrl_q.mem_write;
  assign ex_ALUSrc1  = ctrl_q.alu_src1;
  assign ex_ALUSrc2  = ctrl_q.alu_src2;
  assign ex_RegDst   = ctrl_q.reg_dst;
  assign ex_MemtoReg = ctrl_q.mem_to_reg;
  assign ex_ALUOp    = ctrl_q.alu_op;
  assign ex_Funct    = ctrl_q.funct;
  assign ex_pc_plus4 = pc_plus4_q;
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_shamt    = shamt_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;

`ifdef ID_EX_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters. A bubble caused by flush and hazard together is
  // attributed to the flush only. Both wrap naturally at 2^32.
  // -------------------------------------------------------------------------
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q,  flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush_ex) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (hz) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule
